threshold_detector: RTL
=======================

Name: threshold_detector

Overview:
- Registered, parametrised successor to the three-input pair/triple detector.
- Counts the asserted bits of each valid N-bit sample and compares the count against a runtime threshold.
- Asserts a detection output only after the threshold has been met for HOLD consecutive valid samples.
- Used as a debounced majority/threshold flag feeding control logic; with N=3, thresh=2, HOLD=1 it is a registered pair/triple detector.

Parameters:
- N, 3, number of input bits (N >= 1)
- HOLD, 2, consecutive qualifying valid samples required before out asserts (HOLD >= 1)
- CNT_W, $clog2(N+1), width of popcount and threshold (derived; not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately
- clear  input  1  synchronous clear, active-high
- in_val  input  1  sample strobe; in and thresh are consumed only when 1
- in  input  N  sample bits
- thresh  input  CNT_W  threshold; sample qualifies when popcount(in) >= thresh
- out  output  1  registered detection flag
- count  output  CNT_W  registered popcount of the last accepted sample
- rise  output  1  registered one-cycle pulse on each out 0->1 transition

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, run=0, out=0, count=0, rise=0.
  - Reset asserted mid-hold discards partial run; no rise.
- Priority per edge: reset > clear > in_val.
- clear=1: same values as reset, applied at the edge; in_val ignored that cycle.
- in_val=0: state, run, out and count hold; rise=0.
- in_val=1:
  - count <= pc = popcount(in).
  - qual = (pc >= thresh), unsigned compare.
  - thresh=0 always qualifies.
  - thresh > N never qualifies.
- State machine; run width $clog2(HOLD+1):
  - IDLE (out=0):
    - qual and HOLD==1 -> DETECTED, rise=1.
    - qual and HOLD>1 -> ARMING, run=1.
    - !qual -> stay.
  - ARMING (out=0):
    - qual and run+1==HOLD -> DETECTED, run=0, rise=1.
    - qual otherwise -> run<=run+1.
    - !qual -> IDLE, run=0.
  - DETECTED (out=1):
    - qual -> stay, rise=0.
    - !qual -> IDLE, out=0.
- out is a registered function of state (out=1 iff DETECTED).
- Latency: out rises on the edge that accepts the HOLDth consecutive qualifying sample. It is visible in the cycle after that sample is presented.
- rise is high exactly one cycle per detection, coincident with the first cycle out=1.
- Gaps (in_val=0) between qualifying samples do not break a run; only a non-qualifying valid sample does.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: THRESHOLD_DETECTOR_EVCNT_EN
- Defined:
  - Adds output port evcnt (EVCNT_W=8 bits): saturating count of rise pulses.
  - Increments on each edge where rise is set, holds at 255.
  - Zeroed by reset and clear.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package threshold_detector_pkg:
  - typedef enum logic [1:0] state_t {IDLE=2'b00, ARMING=2'b01, DETECTED=2'b10}
  - localparam EVCNT_W=8
- Sub-module popcount_n: combinational, parameter N, output $clog2(N+1) bits.
  - Also reused by future vote/majority blocks.
- Top module holds the FSM, run counter and output registers.

Test Plan:
- N=3, HOLD=1, thresh=2, in_val=1; exhaustively apply in=000..111 -> out next cycle = 0,0,0,1,0,1,1,1; count = 0,1,1,2,1,2,2,3.
- N=3, HOLD=3, thresh=2; apply 011,110,101 -> out=0,0,1; rise=1 only on third; then 001 -> out=0, rise=0.
- N=3, HOLD=2, thresh=2; apply 011, in_val=0 for 3 cycles, 111 -> out holds 0 during gap, asserts after 111; then 100 -> out=0.
- N=8, HOLD=1; thresh=0 with in=0x00 -> out=1; thresh=9 with in=0xFF -> out=0, count=8.
- Mid-ARMING (HOLD=3, one qualifying sample accepted): pulse reset=0 between edges -> out=0, count=0 immediately. Repeat with clear=1 and in_val=1, in=111 -> IDLE, count=0.
- With THRESHOLD_DETECTOR_EVCNT_EN, HOLD=1: alternate 111/000 for 600 samples -> evcnt saturates at 255; clear -> evcnt=0.

Source files
------------

// File: rtl/threshold_detector_pkg.sv
// rtl/threshold_detector_pkg.sv - shared types and constants for threshold_detector
package threshold_detector_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ARMING   = 2'b01,
      DETECTED = 2'b10
   } state_t;

   localparam int EVCNT_W = 8;

endpackage

// File: rtl/popcount_n.sv
// rtl/popcount_n.sv - combinational count of asserted bits in an N-bit word
module popcount_n #(
   parameter  int N     = 3,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic [N-1:0]     bits,
   output logic [CNT_W-1:0] pc
);

   always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) begin
         pc = pc + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/threshold_detector.sv
// rtl/threshold_detector.sv - debounced popcount threshold flag with rise pulse
// Optional saturating rise counter on port evcnt when THRESHOLD_DETECTOR_EVCNT_EN is defined.
module threshold_detector
   import threshold_detector_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int HOLD  = 2,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_val,
   input  logic [N-1:0]     in,
   input  logic [CNT_W-1:0] thresh,
   output logic             out,
   output logic [CNT_W-1:0] count,
   output logic             rise
`ifdef THRESHOLD_DETECTOR_EVCNT_EN
   ,output logic [EVCNT_W-1:0] evcnt
`endif
);

   localparam int RUN_W = $clog2(HOLD + 1);

   state_t           state, state_nxt;
   logic [RUN_W-1:0] run, run_nxt;
   logic             rise_nxt;
   logic [CNT_W-1:0] pc;
   logic             qual;

   popcount_n #(.N(N)) u_popcount (
      .bits (in),
      .pc   (pc)
   );

   // thresh=0 always passes; thresh>N can never be reached by pc
   assign qual = (pc >= thresh);

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      rise_nxt  = 1'b0;
      if (in_val) begin
         case (state)
            IDLE: begin
               if (qual) begin
                  if (HOLD == 1) begin
                     state_nxt = DETECTED;
                     rise_nxt  = 1'b1;
                  end else begin
                     state_nxt = ARMING;
                     run_nxt   = RUN_W'(1);
                  end
               end
            end
            ARMING: begin
               if (qual) begin
                  if (int'(run) + 1 == HOLD) begin
                     state_nxt = DETECTED;
                     run_nxt   = '0;
                     rise_nxt  = 1'b1;
                  end else begin
                     run_nxt = run + 1'b1;
                  end
               end else begin
                  state_nxt = IDLE;
                  run_nxt   = '0;
               end
            end
            DETECTED: begin
               if (!qual) begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               run_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         run   <= '0;
         out   <= 1'b0;
         count <= '0;
         rise  <= 1'b0;
      end else if (clear) begin
         state <= IDLE;
         run   <= '0;
         out   <= 1'b0;
         count <= '0;
         rise  <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
         out   <= (state_nxt == DETECTED);
         rise  <= rise_nxt;
         if (in_val) begin
            count <= pc;
         end
      end
   end

`ifdef THRESHOLD_DETECTOR_EVCNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evcnt <= '0;
      end else if (clear) begin
         evcnt <= '0;
      end else if (rise && (evcnt != {EVCNT_W{1'b1}})) begin
         evcnt <= evcnt + 1'b1;
      end
   end
`endif

endmodule
